mux_select_sequencer: RTL and testbench

MUX_SELECT_SEQUENCER -- requirements
Module: mux_select_sequencer

---
 rtl/mux_select_sequencer.sv | 150 +++++++++++++++
 tb/tb_mux_select_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mux_select_sequencer.sv
// Channel-select sequencer: scans NUM_CH channels with a settle cycle and a
// DWELL-cycle valid window per channel, or follows a manually requested
// channel. All outputs come straight from flops.
module mux_select_sequencer #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DWELL  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       hold,
  input  logic       manual_en,
  input  logic [1:0] manual_sel,
  output logic [1:0] sel,
  output logic       sel_valid,
  output logic       ch_start,
  output logic       frame_done,
  output logic       busy
);

  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DWELL,
    ST_MANUAL
  } state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stop_pend_q, stop_pend_d;
  logic             hold_q;
  logic             sel_valid_q, sel_valid_d;
  logic             ch_start_q, ch_start_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;
  logic [SEL_W-1:0] man_sel_c;

  // Manual request clamped to the highest implemented channel
  assign man_sel_c = (manual_sel > LAST_SEL) ? LAST_SEL : manual_sel;

  // Next-state, counter and registered-output decode
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    stop_pend_d  = stop_pend_q | (stop & (state_q != ST_IDLE));
    sel_valid_d  = 1'b0;
    ch_start_d   = 1'b0;
    frame_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (manual_en) begin
          state_d     = ST_MANUAL;
          sel_d       = man_sel_c;
          sel_valid_d = (man_sel_c == sel_q);
        end else if (start) begin
          state_d     = ST_SETTLE;
          sel_d       = '0;
          cnt_d       = '0;
          stop_pend_d = stop;
        end
      end
      ST_SETTLE: begin
        state_d     = ST_DWELL;
        cnt_d       = '0;
        sel_valid_d = 1'b1;
        ch_start_d  = 1'b1;
      end
      ST_DWELL: begin
        // hold acts through hold_q so the final cycle is known one edge early
        if ((cnt_q == LAST_CNT) && !hold_q) begin
          cnt_d = '0;
          if (sel_q != LAST_SEL) begin
            state_d = ST_SETTLE;
            sel_d   = sel_q + SEL_W'(1);
          end else if (stop_pend_q || stop) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SETTLE;
            sel_d   = '0;
          end
        end else begin
          sel_valid_d = 1'b1;
          if (!hold_q) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_MANUAL: begin
        if (!manual_en) begin
          state_d = ST_IDLE;
        end else begin
          sel_d       = man_sel_c;
          sel_valid_d = (man_sel_c == sel_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pulse in the cycle that will be the unfrozen last cycle of the frame
    frame_done_d = (state_d == ST_DWELL) && (sel_d == LAST_SEL) &&
                   (cnt_d == LAST_CNT) && !hold;

    if (state_d == ST_IDLE) begin
      stop_pend_d = 1'b0;
    end
  end

  assign busy_d = (state_d != ST_IDLE);

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      cnt_q        <= '0;
      stop_pend_q  <= 1'b0;
      hold_q       <= 1'b0;
      sel_valid_q  <= 1'b0;
      ch_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      stop_pend_q  <= stop_pend_d;
      hold_q       <= hold;
      sel_valid_q  <= sel_valid_d;
      ch_start_q   <= ch_start_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign sel        = sel_q;
  assign sel_valid  = sel_valid_q;
  assign ch_start   = ch_start_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Directed bench for mux_select_sequencer (NUM_CH=2, DWELL=4). Each step
// pushes the outputs expected after the next edge and pops them for compare.
module tb_mux_select_sequencer;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned DWELL  = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       hold;
  logic       manual_en;
  logic [1:0] manual_sel;
  logic [1:0] sel;
  logic       sel_valid;
  logic       ch_start;
  logic       frame_done;
  logic       busy;

  typedef struct packed {
    logic       busy;
    logic [1:0] sel;
    logic       sel_valid;
    logic       ch_start;
    logic       frame_done;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mux_select_sequencer #(.NUM_CH(NUM_CH), .DWELL(DWELL)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .hold       (hold),
    .manual_en  (manual_en),
    .manual_sel (manual_sel),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .ch_start   (ch_start),
    .frame_done (frame_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: queue expected outputs, take the edge, compare
  task automatic tk(input string tag, input logic b, input logic [1:0] s,
                    input logic v, input logic cs, input logic fd);
    obs_t want;
    obs_t got;
    want.busy       = b;
    want.sel        = s;
    want.sel_valid  = v;
    want.ch_start   = cs;
    want.frame_done = fd;
    exp_q.push_back(want);
    @(posedge clk);
    #1;
    got.busy       = busy;
    got.sel        = sel;
    got.sel_valid  = sel_valid;
    got.ch_start   = ch_start;
    got.frame_done = frame_done;
    want = exp_q.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got{busy,sel,v,cs,fd}=%b expected=%b", tag, got, want);
    end
  endtask

  // n valid cycles on channel s; hold_mask[i] is driven in the cycle before cycle i
  task automatic dwell_run(input string tag, input logic [1:0] s, input int n,
                           input logic fd_last, input logic [15:0] hold_mask);
    for (int i = 0; i < n; i++) begin
      hold = hold_mask[i];
      tk(tag, 1'b1, s, 1'b1, (i == 0), fd_last && (i == n - 1));
    end
    hold = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0;
    manual_en = 1'b0; manual_sel = 2'd0;

    // Reset state
    tk("reset", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tk("reset_hold", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tk("idle", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Manual mode with clamping; start ignored while manual
    manual_en = 1'b1; manual_sel = 2'd3;
    tk("man_clamp_chg", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    tk("man_clamp_stable", 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    start = 1'b1;
    tk("man_start_ignored", 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    start = 1'b0; manual_sel = 2'd0;
    tk("man_sel0_chg", 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    tk("man_sel0_stable", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    manual_sel = 2'd2;
    tk("man_sel2_clamp", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    manual_sel = 2'd1;
    tk("man_sel1_same", 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    manual_sel = 2'd0;
    tk("man_sel0_again", 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    manual_en = 1'b0;
    tk("man_exit", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    tk("man_exit_idle", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Free-running scan, period 10; second frame stopped from sel 0
    start = 1'b1;
    tk("scan_settle0", 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    dwell_run("scan_dwell0", 2'd0, 4, 1'b0, 16'h0);
    tk("scan_settle1", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    dwell_run("scan_dwell1", 2'd1, 4, 1'b1, 16'h0);
    tk("scan2_settle0", 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    stop = 1'b1; manual_en = 1'b1; manual_sel = 2'd1;
    dwell_run("scan2_dwell0_stop", 2'd0, 4, 1'b0, 16'h0);
    stop = 1'b0; manual_en = 1'b0; manual_sel = 2'd0;
    tk("scan2_settle1", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    dwell_run("scan2_dwell1", 2'd1, 4, 1'b1, 16'h0);
    tk("stop_idle", 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    stop = 1'b1;
    tk("stop_in_idle", 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    stop = 1'b0;
    tk("idle_retain_sel", 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);

    // Mid-dwell hold stretches channel 0 to 7 cycles (period 13)
    start = 1'b1;
    tk("hold_settle0", 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    dwell_run("hold_dwell0", 2'd0, 7, 1'b0, 16'h001C);
    tk("hold_settle1", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    dwell_run("hold_dwell1", 2'd1, 4, 1'b1, 16'h0);
    tk("hold_next_frame", 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    dwell_run("f2_dwell0", 2'd0, 4, 1'b0, 16'h0);
    tk("f2_settle1", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);

    // Hold over the final cycle postpones frame_done and the advance
    stop = 1'b1;
    dwell_run("final_hold", 2'd1, 6, 1'b1, 16'h0018);
    stop = 1'b0;
    tk("final_hold_idle", 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);

    // start and stop together: exactly one frame
    start = 1'b1; stop = 1'b1;
    tk("once_settle0", 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b0; stop = 1'b0;
    dwell_run("once_dwell0", 2'd0, 4, 1'b0, 16'h0);
    tk("once_settle1", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    dwell_run("once_dwell1", 2'd1, 4, 1'b1, 16'h0);
    tk("once_idle", 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    tk("once_idle2", 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of channel 1 aborts with no frame_done
    start = 1'b1;
    tk("rst_settle0", 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    dwell_run("rst_dwell0", 2'd0, 4, 1'b0, 16'h0);
    tk("rst_settle1", 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    dwell_run("rst_dwell1", 2'd1, 2, 1'b0, 16'h0);
    rst = 1'b1; start = 1'b1; manual_en = 1'b1;
    tk("rst_abort", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b0; manual_en = 1'b0;
    tk("rst_abort_hold", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tk("post_rst_idle", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
